mm2s_cmd_sched: RTL



---
 rtl/mm2s_cmd_sched.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/mm2s_cmd_sched.sv
// mm2s_cmd_sched: round-robin sharing of one DataMover MM2S command channel.
// Each grant emits one command and one tag (data type in tag[62:61]), an
// in-flight limit is enforced, and completions are returned per requester by
// watching tlast on the MM2S data stream.
// Optional: define MM2S_SCHED_PERF_CNT_EN for grant/stall performance counters.
//
// Handshakes: every stream is valid/ready; a transfer happens in a cycle where
// both are high, valid never drops without a transfer, and tdata is held
// constant while valid is high. req_valid/req_ready follow the same rule with
// req_ready as a combinational one-cycle grant strobe.
module mm2s_cmd_sched #(
   parameter int N_REQ           = 3,
   parameter int ADDR_WIDTH      = 32,
   parameter int BTT_WIDTH       = 23,
   parameter int CMD_WIDTH       = 72,
   parameter int TAG_WIDTH       = 64,
   parameter int MAX_OUTSTANDING = 8,
   parameter logic [2*N_REQ-1:0] REQ_TYPES = {2'b10, 2'b11, 2'b00}
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_REQ-1:0]              req_valid,
   output logic [N_REQ-1:0]              req_ready,
   input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
   input  logic [N_REQ*BTT_WIDTH-1:0]    req_btt,
   output logic [N_REQ-1:0]              req_done,
   output logic                          m_axis_mm2s_cmd_tvalid,
   input  logic                          m_axis_mm2s_cmd_tready,
   output logic [CMD_WIDTH-1:0]          m_axis_mm2s_cmd_tdata,
   output logic                          m_axis_mm2s_tag_tvalid,
   input  logic                          m_axis_mm2s_tag_tready,
   output logic [TAG_WIDTH-1:0]          m_axis_mm2s_tag_tdata,
   input  logic                          mon_mm2s_tvalid,
   input  logic                          mon_mm2s_tready,
   input  logic                          mon_mm2s_tlast,
   output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
   output logic                          err_underflow,
   output logic                          dbg_state_o
`ifdef MM2S_SCHED_PERF_CNT_EN
   ,
   output logic [N_REQ*32-1:0]           perf_grant_cnt,
   output logic [31:0]                   perf_stall_cnt
`endif
);

   localparam int IW = (N_REQ > 2) ? 2 : 1;
   localparam int PW = $clog2(MAX_OUTSTANDING);
   localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTSTANDING);

   typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic                   cmd_valid_q, cmd_valid_d;
   logic                   tag_valid_q, tag_valid_d;
   logic [CMD_WIDTH-1:0]   cmd_data_q, cmd_data_d;
   logic [TAG_WIDTH-1:0]   tag_data_q, tag_data_d;
   logic [4:0]             seq_q, seq_d;
   logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
   logic [OW-1:0]          outstanding_q, outstanding_d;
   logic [N_REQ-1:0]       req_done_q;
   logic                   err_q;
   logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
   logic [IW-1:0]          fifo_mem [MAX_OUTSTANDING];

   logic                   found, grant, cpl_ev, pop;
   logic [IW-1:0]          winner;
   logic [1:0]             win_type;
   logic [ADDR_WIDTH-1:0]  sel_addr;
   logic [BTT_WIDTH-1:0]   sel_btt;

   assign cpl_ev = mon_mm2s_tvalid & mon_mm2s_tready & mon_mm2s_tlast;
   assign pop    = cpl_ev & (|outstanding_q);

   // Find the first pending requester at or above rr_ptr_q, wrapping around
   always_comb begin
      found    = 1'b0;
      winner   = '0;
      win_type = '0;
      sel_addr = '0;
      sel_btt  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         for (int j = 0; j < N_REQ; j++) begin
            if (!found && (j == (int'(rr_ptr_q) + i) % N_REQ) && req_valid[j]) begin
               found    = 1'b1;
               winner   = IW'(j);
               win_type = REQ_TYPES[2*j +: 2];
               sel_addr = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
               sel_btt  = req_btt[j*BTT_WIDTH +: BTT_WIDTH];
            end
         end
      end
   end

   // IDLE/ISSUE next state, grant strobe and command/tag formation
   always_comb begin
      state_d     = state_q;
      cmd_valid_d = cmd_valid_q;
      tag_valid_d = tag_valid_q;
      cmd_data_d  = cmd_data_q;
      tag_data_d  = tag_data_q;
      seq_d       = seq_q;
      rr_ptr_d    = rr_ptr_q;
      grant       = 1'b0;
      req_ready   = '0;
      case (state_q)
         IDLE: begin
            if (found && (outstanding_q < MAX_CNT)) begin
               grant       = 1'b1;
               req_ready   = N_REQ'(1) << winner;
               cmd_valid_d = 1'b1;
               tag_valid_d = 1'b1;
               cmd_data_d  = '0;
               cmd_data_d[BTT_WIDTH-1:0]  = sel_btt;
               cmd_data_d[23]             = 1'b1;
               cmd_data_d[30]             = 1'b1;
               cmd_data_d[32 +: ADDR_WIDTH] = sel_addr;
               cmd_data_d[64 +: 4]        = seq_q[3:0];
               tag_data_d  = '0;
               tag_data_d[61 +: 2]        = win_type;
               tag_data_d[56 +: 5]        = seq_q;
               tag_data_d[BTT_WIDTH-1:0]  = sel_btt;
               seq_d       = seq_q + 5'd1;
               rr_ptr_d    = IW'((int'(winner) + 1) % N_REQ);
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            if (m_axis_mm2s_cmd_tready) cmd_valid_d = 1'b0;
            if (m_axis_mm2s_tag_tready) tag_valid_d = 1'b0;
            if (!cmd_valid_d && !tag_valid_d) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // In-flight count: a grant and an accepted completion cancel out
   always_comb begin
      outstanding_d = outstanding_q;
      if (grant && !pop)      outstanding_d = outstanding_q + OW'(1);
      else if (!grant && pop) outstanding_d = outstanding_q - OW'(1);
   end

   // FSM, stream and arbitration registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cmd_valid_q <= 1'b0;
         tag_valid_q <= 1'b0;
         cmd_data_q  <= '0;
         tag_data_q  <= '0;
         seq_q       <= '0;
         rr_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         cmd_valid_q <= cmd_valid_d;
         tag_valid_q <= tag_valid_d;
         cmd_data_q  <= cmd_data_d;
         tag_data_q  <= tag_data_d;
         seq_q       <= seq_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   // Completion ID FIFO storage; occupancy is tracked by outstanding_q
   always_ff @(posedge clk) begin
      if (grant) fifo_mem[wr_ptr_q] <= winner;
   end

   // FIFO pointers, in-flight count, completion pulse and sticky underflow
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         outstanding_q <= '0;
         req_done_q    <= '0;
         err_q         <= 1'b0;
      end else begin
         if (grant) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
         outstanding_q <= outstanding_d;
         req_done_q    <= pop ? (N_REQ'(1) << fifo_mem[rd_ptr_q]) : '0;
         if (cpl_ev && !(|outstanding_q)) err_q <= 1'b1;
      end
   end

   assign m_axis_mm2s_cmd_tvalid = cmd_valid_q;
   assign m_axis_mm2s_cmd_tdata  = cmd_data_q;
   assign m_axis_mm2s_tag_tvalid = tag_valid_q;
   assign m_axis_mm2s_tag_tdata  = tag_data_q;
   assign outstanding            = outstanding_q;
   assign req_done               = req_done_q;
   assign err_underflow          = err_q;
   assign dbg_state_o            = state_q;

`ifdef MM2S_SCHED_PERF_CNT_EN
   logic [N_REQ*32-1:0] perf_grant_q;
   logic [31:0]         perf_stall_q;
   logic                stall;

   assign stall = (state_q == IDLE) && (|req_valid) && (outstanding_q == MAX_CNT);

   // Per-requester grant counters and limit-stall counter, all wrapping
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_grant_q <= '0;
         perf_stall_q <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (grant && (winner == IW'(i)))
               perf_grant_q[i*32 +: 32] <= perf_grant_q[i*32 +: 32] + 32'd1;
         end
         if (stall) perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign perf_grant_cnt = perf_grant_q;
   assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
